// File: rtl/readout_buffer.sv
`default_nettype none
// ============================================================================
// Module   : readout_buffer
// Purpose  : Captures paired column ADC samples on convert strobe rising edges,
//            tags them by row, queues them in a small FIFO and tracks frames.
//            Optional frame counter enabled by macro READOUT_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module readout_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            NRE_1,
    input  logic            NRE_2,
    input  logic            ADC,
    input  logic [DW-1:0]   col1_data,
    input  logic [DW-1:0]   col2_data,
    output logic [2*DW-1:0] pix_data,
    output logic            pix_row,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic            frame_done,
    output logic            overflow,
    output logic            seq_err,
    output logic [7:0]      frame_cnt
);

    localparam int             c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);
    localparam logic [0:0]     c_IDLE = 1'b0;
    localparam logic [0:0]     c_ROW1 = 1'b1;

    logic [2*DW:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_adc_q;
    logic            r_adc_hold;
    logic [0:0]      r_state;
    logic            r_frame_done;
    logic            r_overflow;
    logic            r_seq_err;

    logic w_capture, w_row1, w_row2, w_both, w_push, w_pop, w_full, w_wr;

    // r_adc_hold blocks a strobe that was already high when reset released
    assign w_capture = ADC & ~r_adc_q & ~r_adc_hold;
    assign w_row1    = w_capture & ~NRE_1 &  NRE_2;
    assign w_row2    = w_capture &  NRE_1 & ~NRE_2;
    assign w_both    = w_capture & ~NRE_1 & ~NRE_2;
    assign w_push    = w_row1 | w_row2;
    assign w_pop     = pix_valid & pix_ready;
    assign w_full    = (r_count == c_FULL);
    assign w_wr      = w_push & (~w_full | w_pop);

    assign pix_valid  = (r_count != '0);
    assign pix_data   = r_mem[r_rd_ptr][2*DW-1:0];
    assign pix_row    = r_mem[r_rd_ptr][2*DW];
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign seq_err    = r_seq_err;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {w_row2, col2_data, col1_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_adc_q    <= 1'b0;
            r_adc_hold <= ADC;
            r_overflow <= 1'b0;
        end else begin
            r_adc_q <= ADC;
            if (!ADC) begin
                r_adc_hold <= 1'b0;
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Frame tracking counts captures whether or not the FIFO accepted them
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_frame_done <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_both) begin
                r_seq_err <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_row1) begin
                        r_state <= c_ROW1;
                    end else if (w_row2) begin
                        r_seq_err <= 1'b1;
                    end
                end
                default: begin
                    if (w_row2) begin
                        r_state      <= c_IDLE;
                        r_frame_done <= 1'b1;
                    end else if (w_row1) begin
                        r_seq_err <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef READOUT_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= 8'd0;
        end else if (w_row2 && (r_state == c_ROW1)) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_readout_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_readout_buffer
// Purpose  : Randomized and directed bench for readout_buffer against a
//            queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_readout_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            NRE_1 = 1'b1;
    logic            NRE_2 = 1'b1;
    logic            ADC = 1'b0;
    logic [DW-1:0]   col1_data = '0;
    logic [DW-1:0]   col2_data = '0;
    logic [2*DW-1:0] pix_data;
    logic            pix_row;
    logic            pix_valid;
    logic            pix_ready = 1'b0;
    logic            frame_done;
    logic            overflow;
    logic            seq_err;
    logic [7:0]      frame_cnt;

    readout_buffer #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .NRE_1     (NRE_1),
        .NRE_2     (NRE_2),
        .ADC       (ADC),
        .col1_data (col1_data),
        .col2_data (col2_data),
        .pix_data  (pix_data),
        .pix_row   (pix_row),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .frame_done(frame_done),
        .overflow  (overflow),
        .seq_err   (seq_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: queue of {row, col2, col1}
    logic [2*DW:0] q[$];
    bit            m_prev = 1'b0;
    bit            m_in_row1 = 1'b0;
    bit            m_fd = 1'b0;
    bit            m_ov = 1'b0;
    bit            m_se = 1'b0;
    logic [7:0]    m_fc = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit cap, both, r1, r2, pop, acc;
        if (reset) begin
            q.delete();
            m_prev = ADC;
            m_in_row1 = 0; m_fd = 0; m_ov = 0; m_se = 0; m_fc = 0;
            return;
        end
        cap  = ADC && !m_prev;
        m_prev = ADC;
        r1   = cap && !NRE_1 && NRE_2;
        r2   = cap && NRE_1 && !NRE_2;
        both = cap && !NRE_1 && !NRE_2;
        pop  = (q.size() != 0) && pix_ready;
        acc  = (r1 || r2) && !(q.size() == DEPTH && !pop);
        if ((r1 || r2) && !acc) m_ov = 1;
        if (both) m_se = 1;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back({r2, col2_data, col1_data});
        m_fd = 0;
        if (r1) begin
            if (m_in_row1) m_se = 1;
            m_in_row1 = 1;
        end
        if (r2) begin
            if (m_in_row1) begin
                m_in_row1 = 0;
                m_fd = 1;
`ifdef READOUT_FRAME_CNT_EN
                m_fc = m_fc + 8'd1;
`endif
            end else begin
                m_se = 1;
            end
        end
    endtask

    task automatic compare();
        chk("pix_valid", pix_valid, (q.size() != 0));
        if (q.size() != 0) begin
            chk("pix_data", pix_data, q[0][2*DW-1:0]);
            chk("pix_row", pix_row, q[0][2*DW]);
        end
        chk("frame_done", frame_done, m_fd);
        chk("overflow", overflow, m_ov);
        chk("seq_err", seq_err, m_se);
        chk("frame_cnt", frame_cnt, m_fc);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        ADC = 0; NRE_1 = 1; NRE_2 = 1; pix_ready = 0;
        reset = 1; cyc(); cyc();
        reset = 0; cyc();
    endtask

    task automatic cap(input bit r2, input logic [7:0] c1, input logic [7:0] c2);
        NRE_1 = r2; NRE_2 = !r2; col1_data = c1; col2_data = c2; ADC = 1;
        cyc();
        ADC = 0; NRE_1 = 1; NRE_2 = 1;
        cyc();
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_valid", pix_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_seq_err", seq_err, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        // Basic frame: row 1 then row 2, then drain
        cap(0, 8'h12, 8'h34);
        chk("f1_head", pix_data, 16'h3412);
        chk("f1_row", pix_row, 0);
        NRE_1 = 1; NRE_2 = 0; col1_data = 8'h56; col2_data = 8'h78; ADC = 1;
        cyc();
        chk("f1_done_pulse", frame_done, 1);
        ADC = 0; NRE_2 = 1;
        cyc();
        chk("f1_done_end", frame_done, 0);
        pix_ready = 1;
        cyc();
        chk("f1_second", pix_data, 16'h7856);
        chk("f1_second_row", pix_row, 1);
        cyc();
        chk("f1_empty", pix_valid, 0);
`ifdef READOUT_FRAME_CNT_EN
        chk("f1_cnt", frame_cnt, 1);
`else
        chk("f1_cnt", frame_cnt, 0);
`endif

        // Overflow: five captures into four entries
        do_reset();
        for (int i = 0; i < 5; i++) cap(0, 8'(i), 8'(8'hA0 + i));
        chk("ovf_valid", pix_valid, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", pix_data, 16'hA000);
        pix_ready = 1;
        for (int i = 0; i < 4; i++) cyc();
        chk("ovf_drained", pix_valid, 0);

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < 4; i++) cap(0, 8'(i), 8'(8'hA0 + i));
        NRE_1 = 0; col1_data = 8'h55; col2_data = 8'h66; ADC = 1; pix_ready = 1;
        cyc();
        pix_ready = 0; ADC = 0; NRE_1 = 1;
        cyc();
        chk("full_pp_ovf", overflow, 0);
        chk("full_pp_head", pix_data, 16'hA101);
        pix_ready = 1;
        for (int i = 0; i < 4; i++) cyc();
        chk("full_pp_drained", pix_valid, 0);

        // Strobe held high gives one capture; both enables low is an error
        do_reset();
        NRE_1 = 0; ADC = 1;
        for (int i = 0; i < 3; i++) cyc();
        ADC = 0; NRE_1 = 1;
        cyc();
        chk("hold_valid", pix_valid, 1);
        pix_ready = 1;
        cyc();
        chk("hold_one_push", pix_valid, 0);
        pix_ready = 0;
        NRE_1 = 0; NRE_2 = 0; ADC = 1;
        cyc();
        ADC = 0; NRE_1 = 1; NRE_2 = 1;
        cyc();
        chk("both_seq_err", seq_err, 1);
        chk("both_no_push", pix_valid, 0);

        // Reset mid-frame, then an orphan row 2
        do_reset();
        cap(0, 8'h11, 8'h22);
        reset = 1; cyc(); reset = 0;
        cap(1, 8'h9A, 8'hBC);
        chk("midrst_row", pix_row, 1);
        chk("midrst_data", pix_data, 16'hBC9A);
        chk("midrst_seq_err", seq_err, 1);
        pix_ready = 1;
        cyc();
        chk("midrst_only_one", pix_valid, 0);

        // Strobe high across reset release must not capture
        NRE_1 = 0; ADC = 1; reset = 1; pix_ready = 0;
        cyc();
        reset = 0;
        cyc(); cyc();
        chk("adc_across_reset", pix_valid, 0);
        ADC = 0; NRE_1 = 1;
        cyc();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            int r;
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) ADC = ~ADC;
            r = $urandom_range(0, 9);
            NRE_1 = !(r == 0 || (r >= 1 && r <= 4));
            NRE_2 = !(r == 0 || (r >= 5 && r <= 8));
            col1_data = 8'($urandom);
            col2_data = 8'($urandom);
            pix_ready = ($urandom_range(0, 99) < ((k < 1500) ? 20 : 70));
            cyc();
        end

        // 256 complete frames
        do_reset();
        pix_ready = 1;
        for (int f = 0; f < 256; f++) begin
            cap(0, 8'(f), 8'h01);
            cap(1, 8'(f), 8'h02);
            if (f == 254) begin
`ifdef READOUT_FRAME_CNT_EN
                chk("cnt_255", frame_cnt, 255);
`else
                chk("cnt_255", frame_cnt, 0);
`endif
            end
        end
        chk("cnt_wrap", frame_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
